fifo_thd_burst: RTL and testbench

//  Threshold-release FIFO: buffers a word stream and releases it downstream only in bursts. A burst

---
 rtl/fifo_thd_burst.sv | 137 +++++++++++++
 tb/tb_fifo_thd_burst.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_thd_burst.sv
// fifo_thd_burst: threshold-release FIFO. Words are buffered and released
// downstream only as bursts of thd_e = max(1, min(cfg_thd, DEPTH)) words.
// dout/dout_vld form a registered one-entry output stage with a ready handshake.
// Optional feature macro: THD_TIMEOUT_EN. When it is defined, a residual
// below-threshold fill is flushed after cfg_tout idle cycles.
module fifo_thd_burst #(
   parameter int DW    = 8,
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] din,
   input  logic          din_vld,
   input  logic [CW-1:0] cfg_thd,
   input  logic [15:0]   cfg_tout,
   output logic [DW-1:0] dout,
   output logic          dout_vld,
   input  logic          dout_rdy,
   output logic          busy,
   output logic          ovf_err,
   output logic [CW-1:0] fifo_cnt
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {IDLE, SEND} state_t;

   state_t        state;
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] cnt;
   logic [CW-1:0] thd_e;
   logic [CW-1:0] rem;        // words of the burst not yet transferred downstream
   logic [CW-1:0] fetch_rem;  // words of the burst not yet popped into the output register
   logic          full, wr_acc, pop, xfer, tout_fire;

   // full is the pre-edge count, so a write while full is dropped even if a read coincides
   assign full     = (cnt == CW'(DEPTH));
   assign wr_acc   = din_vld & ~full;
   assign xfer     = dout_vld & dout_rdy;
   // output register refills whenever it is empty or being drained this cycle
   assign pop      = (state == SEND) && (fetch_rem != '0) && (!dout_vld || dout_rdy);
   assign ovf_err  = din_vld & full;
   assign busy     = (state == SEND);
   assign fifo_cnt = cnt;

   // effective threshold: clamp cfg_thd into 1..DEPTH
   always_comb begin
      thd_e = cfg_thd;
      if (cfg_thd == '0)
         thd_e = CW'(1);
      else if (cfg_thd > CW'(DEPTH))
         thd_e = CW'(DEPTH);
   end

`ifdef THD_TIMEOUT_EN
   logic [15:0] idle_cnt;

   // idle counter: runs only while IDLE with words parked and no writes arriving
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         idle_cnt <= '0;
      else if (wr_acc || state == SEND || cnt == '0)
         idle_cnt <= '0;
      else if (idle_cnt != 16'hFFFF)
         idle_cnt <= idle_cnt + 16'd1;
   end

   assign tout_fire = (cfg_tout != '0) && (idle_cnt >= cfg_tout) &&
                      (cnt != '0) && (cnt < thd_e);
`else
   logic unused_tout;
   assign unused_tout = ^cfg_tout;
   assign tout_fire   = 1'b0;
`endif

   // storage array, written only for accepted words
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wptr] <= din;
   end

   // pointers wrap modulo DEPTH; count carries the extra bit for full vs empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (wr_acc) wptr <= wptr + 1'b1;
         if (pop)    rptr <= rptr + 1'b1;
         cnt <= cnt + CW'(wr_acc) - CW'(pop);
      end
   end

   // burst FSM with the registered output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rem       <= '0;
         fetch_rem <= '0;
         dout      <= '0;
         dout_vld  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               dout_vld <= 1'b0;
               if (cnt >= thd_e) begin
                  state     <= SEND;
                  rem       <= thd_e;
                  fetch_rem <= thd_e;
               end else if (tout_fire) begin
                  state     <= SEND;
                  rem       <= cnt;
                  fetch_rem <= cnt;
               end
            end
            SEND: begin
               if (pop) begin
                  dout      <= mem[rptr];
                  dout_vld  <= 1'b1;
                  fetch_rem <= fetch_rem - 1'b1;
               end else if (xfer) begin
                  dout_vld <= 1'b0;
               end
               if (xfer) begin
                  rem <= rem - 1'b1;
                  if (rem == CW'(1))
                     state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_thd_burst.sv
// Directed bench for fifo_thd_burst (DW=8, DEPTH=16): a vector table for the
// threshold burst, plus hand-written sequences for multi-cycle corner cases.
module tb_fifo_thd_burst;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din;
   logic       din_vld;
   logic [4:0] cfg_thd;
   logic [15:0] cfg_tout;
   logic [7:0] dout;
   logic       dout_vld;
   logic       dout_rdy;
   logic       busy;
   logic       ovf_err;
   logic [4:0] fifo_cnt;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       din_vld;
      logic [7:0] din;
      logic       rdy;
      logic       e_vld;
      logic [7:0] e_dout;
      logic       e_busy;
      logic [4:0] e_cnt;
      logic       e_ovf;
   } vec_t;

   vec_t tbl[23];

   fifo_thd_burst #(.DW(8), .DEPTH(16), .CW(5)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
      .cfg_thd(cfg_thd), .cfg_tout(cfg_tout), .dout(dout), .dout_vld(dout_vld),
      .dout_rdy(dout_rdy), .busy(busy), .ovf_err(ovf_err), .fifo_cnt(fifo_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // drive one cycle's inputs just after the falling edge, settle, then let the caller check
   task automatic drive(input logic v, input logic [7:0] d, input logic r);
      @(negedge clk);
      din_vld  = v;
      din      = d;
      dout_rdy = r;
      #1;
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      drive(v.din_vld, v.din, v.rdy);
      chk($sformatf("tbl[%0d].dout_vld", idx), 32'(dout_vld), 32'(v.e_vld));
      chk($sformatf("tbl[%0d].busy", idx), 32'(busy), 32'(v.e_busy));
      chk($sformatf("tbl[%0d].fifo_cnt", idx), 32'(fifo_cnt), 32'(v.e_cnt));
      chk($sformatf("tbl[%0d].ovf_err", idx), 32'(ovf_err), 32'(v.e_ovf));
      if (v.e_vld)
         chk($sformatf("tbl[%0d].dout", idx), 32'(dout), 32'(v.e_dout));
   endtask

   initial begin
      logic [7:0] held;
      logic       hold;
      int         got;
      logic [7:0] w3 [4];

      // threshold-10 burst: writes in cycles 0..9, SEND from cycle 11,
      // words 0x01..0x0A visible in cycles 12..21, idle again in cycle 22
      for (int i = 0; i < 23; i++) begin
         tbl[i].din_vld = (i < 10);
         tbl[i].din     = (i < 10) ? 8'(i + 1) : 8'h00;
         tbl[i].rdy     = 1'b1;
         tbl[i].e_vld   = (i >= 12 && i <= 21);
         tbl[i].e_dout  = (i >= 12 && i <= 21) ? 8'(i - 11) : 8'h00;
         tbl[i].e_busy  = (i >= 11 && i <= 21);
         tbl[i].e_cnt   = (i < 10) ? 5'(i) : (i < 12) ? 5'd10 : (i <= 21) ? 5'(21 - i) : 5'd0;
         tbl[i].e_ovf   = 1'b0;
      end

      rst_n = 1'b0; din = '0; din_vld = 1'b0; dout_rdy = 1'b0;
      cfg_thd = 5'd10; cfg_tout = 16'd0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset dout_vld", 32'(dout_vld), 0);
      chk("reset busy", 32'(busy), 0);
      chk("reset fifo_cnt", 32'(fifo_cnt), 0);
      chk("reset dout", 32'(dout), 0);
      chk("reset ovf_err", 32'(ovf_err), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: threshold burst from the table
      for (int i = 0; i < 23; i++) apply_vec(tbl[i], i);

      // 2: below threshold parks indefinitely, 4th write releases 4 words
      cfg_thd = 5'd4;
      for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'hD1 + i), 1'b1);
      for (int i = 0; i < 100; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         if (i % 10 == 9) begin
            chk("park dout_vld", 32'(dout_vld), 0);
            chk("park fifo_cnt", 32'(fifo_cnt), 3);
         end
      end
      drive(1'b1, 8'hD4, 1'b1);
      chk("t2 pre-trigger cnt", 32'(fifo_cnt), 3);
      drive(1'b0, 8'h00, 1'b1);
      chk("t2 N+0 cnt", 32'(fifo_cnt), 4);
      chk("t2 N+0 busy", 32'(busy), 0);
      drive(1'b0, 8'h00, 1'b1);
      chk("t2 N+1 busy", 32'(busy), 1);
      chk("t2 N+1 dout_vld", 32'(dout_vld), 0);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 8'h00, 1'b1);
         chk("t2 burst vld", 32'(dout_vld), 1);
         chk("t2 burst dout", 32'(dout), 32'(8'hD1 + k));
      end
      drive(1'b0, 8'h00, 1'b1);
      chk("t2 end vld", 32'(dout_vld), 0);
      chk("t2 end busy", 32'(busy), 0);

      // 3: ready toggling during the burst: in order, held, no duplicates
      w3[0] = 8'hB1; w3[1] = 8'hB2; w3[2] = 8'hB3; w3[3] = 8'hB4;
      for (int i = 0; i < 4; i++) drive(1'b1, w3[i], 1'b0);
      got = 0; hold = 1'b0; held = '0;
      for (int c = 0; c < 30; c++) begin
         drive(1'b0, 8'h00, (c % 2) == 0);
         if (hold) begin
            chk("t3 held vld", 32'(dout_vld), 1);
            chk("t3 held dout", 32'(dout), 32'(held));
         end
         if (dout_vld && dout_rdy) begin
            if (got < 4) chk("t3 word", 32'(dout), 32'(w3[got]));
            got++;
         end
         hold = dout_vld && !dout_rdy;
         held = dout;
      end
      chk("t3 words delivered", 32'(got), 4);

      // 4: clamp to 16, overflow on 17th write while stalled, then drain exactly 16
      cfg_thd = 5'd20;
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 8'(8'hE0 + i), 1'b0);
         chk($sformatf("t4 ovf_err w%0d", i), 32'(ovf_err), 32'(i == 16));
      end
      drive(1'b0, 8'h00, 1'b0);
      chk("t4 full cnt", 32'(fifo_cnt), 16);
      got = 0;
      for (int c = 0; c < 40; c++) begin
         drive(1'b0, 8'h00, 1'b1);
         if (dout_vld) begin
            if (got < 16) chk("t4 word", 32'(dout), 32'(8'hE0 + got));
            got++;
         end
      end
      chk("t4 words delivered", 32'(got), 16);
      chk("t4 final cnt", 32'(fifo_cnt), 0);

`ifdef THD_TIMEOUT_EN
      // 5: idle timeout flushes a residual 2-word fill
      cfg_thd = 5'd8; cfg_tout = 16'd5;
      drive(1'b1, 8'hA1, 1'b1);
      drive(1'b1, 8'hA2, 1'b1);
      for (int c = 0; c < 5; c++) begin
         drive(1'b0, 8'h00, 1'b1);
         chk("t5 early vld", 32'(dout_vld), 0);
      end
      got = 0;
      for (int c = 0; c < 20; c++) begin
         drive(1'b0, 8'h00, 1'b1);
         if (dout_vld) begin
            if (got < 2) chk("t5 word", 32'(dout), 32'(8'hA1 + got));
            got++;
         end
      end
      chk("t5 words delivered", 32'(got), 2);
      cfg_tout = 16'd0;
`endif

      // 6: reset mid-burst clears everything at once, then the table replays
      cfg_thd = 5'd10;
      for (int i = 0; i < 10; i++) drive(1'b1, 8'(8'h51 + i), 1'b1);
      got = 0;
      for (int c = 0; c < 10 && !dout_vld; c++) begin
         drive(1'b0, 8'h00, 1'b1);
         got++;
      end
      chk("t6 burst started", 32'(dout_vld), 1);
      drive(1'b0, 8'h00, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6 rst dout_vld", 32'(dout_vld), 0);
      chk("t6 rst busy", 32'(busy), 0);
      chk("t6 rst fifo_cnt", 32'(fifo_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 23; i++) apply_vec(tbl[i], i);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
